// File: rtl/list_sum_datapath.sv
// Datapath of the linked-list sum engine: node memory, SUM accumulator, NEXT pointer.
// Optional loop guard (step counter + sticky loop_err) enabled by defining LOOP_GUARD_EN.
module list_sum_datapath #(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int HEAD_ADDR = 0,
    parameter int MAX_NODES = 2**(AW-1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LD_SUM,
    input  logic          LD_NEXT,
    input  logic          SUM_SEL,
    input  logic          NEXT_SEL,
    input  logic          A_SEL,
    input  logic          DONE,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic          next_zero,
    output logic [DW-1:0] sum_out,
    output logic          loop_err
);

    localparam int            DEPTH      = 2**AW;
    localparam logic [AW-1:0] HEAD       = AW'(HEAD_ADDR);
    localparam logic [AW-1:0] ONE_A      = AW'(1);
    localparam logic [AW-1:0] ZERO_A     = AW'(0);
    localparam logic [AW-1:0] GUARD_LAST = AW'(MAX_NODES - 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] sum_q, sum_d;
    logic [AW-1:0] next_q, next_d;
    logic [AW-1:0] raddr_s;
    logic [DW-1:0] rdata_s;
    logic [AW-1:0] nextmux_s;
    logic          idle_s;
    logic          ptr_zero_s;
    logic          guard_hit_s;

    // Node memory write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read address, asynchronous read and pointer mux.
    always_comb begin
        raddr_s    = A_SEL ? next_q : (next_q + ONE_A);
        rdata_s    = mem_q[raddr_s];
        nextmux_s  = NEXT_SEL ? rdata_s[AW-1:0] : HEAD;
        ptr_zero_s = (nextmux_s == ZERO_A);
        idle_s     = ~(LD_SUM | LD_NEXT | SUM_SEL | NEXT_SEL | A_SEL | DONE);
    end

    // Next-state of the accumulator and pointer; idle decode wins over loads.
    always_comb begin
        sum_d  = sum_q;
        next_d = next_q;
        if (idle_s) begin
            sum_d  = {DW{1'b0}};
            next_d = HEAD;
        end else begin
            if (LD_SUM) begin
                sum_d = SUM_SEL ? (sum_q + rdata_s) : {DW{1'b0}};
            end else begin
                sum_d = sum_q;
            end
            if (LD_NEXT) begin
                next_d = nextmux_s;
            end else begin
                next_d = next_q;
            end
        end
    end

    // SUM and NEXT registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q  <= {DW{1'b0}};
            next_q <= HEAD;
        end else begin
            sum_q  <= sum_d;
            next_q <= next_d;
        end
    end

`ifdef LOOP_GUARD_EN
    logic [AW-1:0] step_q, step_d;
    logic          loop_err_q, loop_err_d;

    // The guard fires on the MAX_NODES-th pointer load of a run.
    always_comb begin
        guard_hit_s = LD_NEXT & (step_q == GUARD_LAST);
        step_d      = step_q;
        loop_err_d  = loop_err_q;
        if (idle_s) begin
            step_d     = ZERO_A;
            loop_err_d = 1'b0;
        end else begin
            if (LD_NEXT) begin
                step_d = step_q + ONE_A;
            end else begin
                step_d = step_q;
            end
            if (guard_hit_s) begin
                loop_err_d = 1'b1;
            end else begin
                loop_err_d = loop_err_q;
            end
        end
    end

    // Step counter and sticky loop error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q     <= ZERO_A;
            loop_err_q <= 1'b0;
        end else begin
            step_q     <= step_d;
            loop_err_q <= loop_err_d;
        end
    end

    assign loop_err = loop_err_q;
`else
    logic unused_guard_s;

    // Without the guard a cyclic list is never cut short.
    always_comb begin
        guard_hit_s    = 1'b0;
        unused_guard_s = &GUARD_LAST;
    end

    assign loop_err = 1'b0;
`endif

    assign next_zero = ptr_zero_s | guard_hit_s;
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_list_sum_datapath.sv
// Self-checking bench: drives the list-sum FSM sequence and compares against a list-walk model.
module tb_list_sum_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic       LD_SUM, LD_NEXT, SUM_SEL, NEXT_SEL, A_SEL, DONE;
    logic       we;
    logic [3:0] waddr;
    logic [7:0] wdata;
    logic       next_zero;
    logic [7:0] sum_out;
    logic       loop_err;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mdl_mem [16];

    list_sum_datapath #(.AW(4), .DW(8), .HEAD_ADDR(0)) dut (
        .clk(clk), .rst(rst),
        .LD_SUM(LD_SUM), .LD_NEXT(LD_NEXT), .SUM_SEL(SUM_SEL),
        .NEXT_SEL(NEXT_SEL), .A_SEL(A_SEL), .DONE(DONE),
        .we(we), .waddr(waddr), .wdata(wdata),
        .next_zero(next_zero), .sum_out(sum_out), .loop_err(loop_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctl(input logic ls, input logic ln, input logic ss,
                           input logic ns, input logic as, input logic dn);
        LD_SUM = ls; LD_NEXT = ln; SUM_SEL = ss; NEXT_SEL = ns; A_SEL = as; DONE = dn;
    endtask

    task automatic wr(input int a, input int d);
        we = 1'b1; waddr = a[3:0]; wdata = d[7:0];
        step();
        we = 1'b0;
        mdl_mem[a] = d[7:0];
    endtask

    task automatic go_idle();
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
    endtask

    // Reference: walk the list in the shadow memory using the node rules directly.
    task automatic walk(output int sum, output int steps, output bit err);
        int a;
        int p;
        a = 0; sum = 0; steps = 0; err = 1'b0;
        while (steps < 200) begin
            sum = (sum + int'(mdl_mem[a])) % 256;
            steps++;
            p = int'(mdl_mem[(a + 1) % 16]) % 16;
`ifdef LOOP_GUARD_EN
            if (steps == 8) begin
                err = 1'b1;
                break;
            end
`endif
            if (p == 0) break;
            a = p;
        end
    endtask

    // FSM driver: COMPUTE_SUM / GET_NEXT pairs until next_zero, then DONE.
    task automatic run(input int max_nodes, output int steps, output bit done);
        steps = 0; done = 1'b0;
        for (int k = 0; k < max_nodes; k++) begin
            set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            step();
            set_ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            #1;
            steps++;
            done = next_zero;
            step();
            if (done) break;
        end
        if (done) set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
    endtask

    task automatic check_run(input string tag, input bit from_idle);
        int  e_sum, e_steps, g_steps;
        bit  e_err, g_done;
        walk(e_sum, e_steps, e_err);
        if (from_idle) go_idle();
        run(60, g_steps, g_done);
        if (e_steps < 200) begin
            check_val({tag, "_done"}, 32'(g_done), 32'd1);
            check_val({tag, "_steps"}, 32'(g_steps), 32'(e_steps));
            check_val({tag, "_sum"}, 32'(sum_out), 32'(e_sum));
            check_val({tag, "_err"}, 32'(loop_err), 32'(e_err));
        end else begin
            check_val({tag, "_nodone"}, 32'(g_done), 32'd0);
        end
    endtask

    task automatic load_t1();
        wr(0, 5); wr(1, 4); wr(4, 7); wr(5, 8); wr(8, 9); wr(9, 0);
    endtask

    initial begin
        int  addrs [7];
        int  n, j, t, tgt;
        bit  cyc;
        string tg;

        rst = 1'b0; we = 1'b0; waddr = 4'd0; wdata = 8'd0;
        set_ctl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        check_val("rst_sum", 32'(sum_out), 32'd0);
        check_val("rst_err", 32'(loop_err), 32'd0);
        step();
        rst = 1'b1;
        for (int a = 0; a < 16; a++) wr(a, 0);

        // Test 1: three-node list.
        load_t1();
        check_run("t1", 1'b1);
        check_val("t1_const", 32'(sum_out), 32'd21);

        // Test 2: single node.
        wr(0, 3); wr(1, 0);
        check_run("t2", 1'b1);
        check_val("t2_const", 32'(sum_out), 32'd3);

        // Test 3: accumulator wraps.
        wr(0, 200); wr(1, 2); wr(2, 100); wr(3, 0);
        check_run("t3", 1'b1);
        check_val("t3_const", 32'(sum_out), 32'd44);

        // Test 4: cyclic list.
        wr(0, 1); wr(1, 4); wr(4, 1); wr(5, 4);
        check_run("t4", 1'b1);
`ifdef LOOP_GUARD_EN
        check_val("t4_const", 32'(sum_out), 32'd8);
        check_val("t4_sticky", 32'(loop_err), 32'd1);
`endif
        go_idle();
        check_val("t4_clr_err", 32'(loop_err), 32'd0);
        check_val("t4_clr_sum", 32'(sum_out), 32'd0);

        // Test 5: reset during COMPUTE_SUM, then restart straight from reset state.
        load_t1();
        go_idle();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); step();
        set_ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); step();
        set_ctl(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_val("t5_rst_sum", 32'(sum_out), 32'd0);
        step();
        rst = 1'b1;
        check_run("t5_rerun", 1'b0);
        check_val("t5_const", 32'(sum_out), 32'd21);

        // Test 6: idle clear then patch a node value.
        go_idle();
        check_val("t6_clr", 32'(sum_out), 32'd0);
        wr(4, 10);
        check_run("t6", 1'b1);
        check_val("t6_const", 32'(sum_out), 32'd24);

        // Randomized lists, some cyclic; pointer words carry junk in the upper nibble.
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < 16; a++) wr(a, int'($urandom_range(0, 255)));
            for (int k = 0; k < 7; k++) addrs[k] = 2 * (k + 1);
            for (int k = 6; k > 0; k--) begin
                j = int'($urandom_range(0, k));
                t = addrs[k]; addrs[k] = addrs[j]; addrs[j] = t;
            end
            n   = int'($urandom_range(0, 5));
            cyc = (n > 0) && ($urandom_range(0, 3) == 0);
            wr(1, int'($urandom_range(0, 15)) * 16 + ((n > 0) ? addrs[0] : 0));
            for (int k = 0; k < n; k++) begin
                if (k < n - 1) tgt = addrs[k + 1];
                else if (cyc) tgt = addrs[int'($urandom_range(0, n - 1))];
                else tgt = 0;
                wr(addrs[k] + 1, int'($urandom_range(0, 15)) * 16 + tgt);
            end
            tg = $sformatf("r%0d", it);
            check_run(tg, 1'b1);
        end

        go_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
